quad_decoder: RTL and testbench

//   Quadrature decoder for incremental encoder inputs A/B. Synchronises and glitch-filters

---
 rtl/quad_decoder.sv | 144 ++++++++++++++
 tb/tb_quad_decoder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronises and glitch-filters encoder phases A/B, decodes
// Gray-code quarter-steps into step/dir pulses and a wrapping up/down position count.
module quad_decoder #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER      = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             clear,
    input  logic             err_clr,
    output logic [WIDTH-1:0] count,
    output logic             step,
    output logic             dir,
    output logic             err
);

    localparam int CW = $clog2(FILTER + 1);

    logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
    logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d;
    logic [1:0]             smp_s;
    logic [1:0]             prev_q, prev_d;
    logic [1:0]             state_q, state_d;
    logic [1:0]             ev_old_q, ev_old_d;
    logic [CW-1:0]          flt_cnt_q, flt_cnt_d;
    logic [CW-1:0]          cnt_next_s;
    logic                   differ_s;
    logic                   init_q, init_d;
    logic                   ev_q, ev_d;
    logic [WIDTH-1:0]       count_q, count_d;
    logic                   step_q, step_d;
    logic                   dir_q, dir_d;
    logic                   err_q, err_d;

    assign a_sync_d = {a_sync_q[SYNC_STAGES-2:0], a_in};
    assign b_sync_d = {b_sync_q[SYNC_STAGES-2:0], b_in};
    assign smp_s    = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

    // Filter: accept a new A/B value after FILTER consecutive identical differing samples.
    // Before the first acceptance any stable value counts as different, so it gets loaded.
    always_comb begin
        prev_d     = smp_s;
        state_d    = state_q;
        init_d     = init_q;
        ev_d       = 1'b0;
        ev_old_d   = ev_old_q;
        flt_cnt_d  = {CW{1'b0}};
        cnt_next_s = {CW{1'b0}};
        differ_s   = !init_q || (smp_s != state_q);
        if (differ_s) begin
            if (smp_s == prev_q) begin
                cnt_next_s = flt_cnt_q + CW'(1);
            end else begin
                cnt_next_s = CW'(1);
            end
        end else begin
            cnt_next_s = {CW{1'b0}};
        end
        if (differ_s && (cnt_next_s == CW'(FILTER))) begin
            state_d   = smp_s;
            init_d    = 1'b1;
            ev_d      = init_q;
            ev_old_d  = state_q;
            flt_cnt_d = {CW{1'b0}};
        end else begin
            flt_cnt_d = cnt_next_s;
        end
    end

    // Decode the registered old->new transition; clear beats counting, err set beats err_clr.
    always_comb begin
        count_d = count_q;
        step_d  = 1'b0;
        dir_d   = dir_q;
        err_d   = err_clr ? 1'b0 : err_q;
        if (ev_q) begin
            case ({ev_old_q, state_q})
                4'b0010, 4'b1011, 4'b1101, 4'b0100: begin
                    count_d = count_q + WIDTH'(1);
                    step_d  = 1'b1;
                    dir_d   = 1'b1;
                end
                4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
                    count_d = count_q - WIDTH'(1);
                    step_d  = 1'b1;
                    dir_d   = 1'b0;
                end
                4'b0011, 4'b1100, 4'b0110, 4'b1001: begin
                    err_d = 1'b1;
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end else begin
            step_d = 1'b0;
        end
        if (clear) begin
            count_d = {WIDTH{1'b0}};
        end else begin
            count_d = count_d;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sync_q  <= {SYNC_STAGES{1'b0}};
            b_sync_q  <= {SYNC_STAGES{1'b0}};
            prev_q    <= 2'b00;
            state_q   <= 2'b00;
            ev_old_q  <= 2'b00;
            flt_cnt_q <= {CW{1'b0}};
            init_q    <= 1'b0;
            ev_q      <= 1'b0;
            count_q   <= {WIDTH{1'b0}};
            step_q    <= 1'b0;
            dir_q     <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            a_sync_q  <= a_sync_d;
            b_sync_q  <= b_sync_d;
            prev_q    <= prev_d;
            state_q   <= state_d;
            ev_old_q  <= ev_old_d;
            flt_cnt_q <= flt_cnt_d;
            init_q    <= init_d;
            ev_q      <= ev_d;
            count_q   <= count_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
        end
    end

    assign count = count_q;
    assign step  = step_q;
    assign dir   = dir_q;
    assign err   = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder with default parameters (6-edge input-to-output latency).
module tb_quad_decoder;

    logic       clk;
    logic       reset;
    logic       a_in;
    logic       b_in;
    logic       clear;
    logic       err_clr;
    logic [7:0] count;
    logic       step;
    logic       dir;
    logic       err;

    int total;
    int bad;
    int pulses;
    int p0;

    quad_decoder #(.WIDTH(8), .SYNC_STAGES(2), .FILTER(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .a_in    (a_in),
        .b_in    (b_in),
        .clear   (clear),
        .err_clr (err_clr),
        .count   (count),
        .step    (step),
        .dir     (dir),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count step pulses away from the rising edge.
    always @(negedge clk) begin
        if (step === 1'b1) pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive new A/B, check nothing appears at edge 5, expected result at edge 6, pulse gone at 7.
    task automatic do_step(input logic a, input logic b, input logic [7:0] e_cnt,
                           input logic e_dir, input logic e_step, input logic e_err,
                           input logic clr, input logic eclr, input string tag);
        @(negedge clk);
        a_in = a;
        b_in = b;
        repeat (5) @(posedge clk);
        #1;
        chk({tag, "_early_step"}, {31'd0, step}, 32'd0);
        clear   = clr;
        err_clr = eclr;
        @(posedge clk);
        #1;
        chk({tag, "_step"}, {31'd0, step}, {31'd0, e_step});
        chk({tag, "_count"}, {24'd0, count}, {24'd0, e_cnt});
        chk({tag, "_dir"}, {31'd0, dir}, {31'd0, e_dir});
        chk({tag, "_err"}, {31'd0, err}, {31'd0, e_err});
        clear   = 1'b0;
        err_clr = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_step_off"}, {31'd0, step}, 32'd0);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        pulses  = 0;
        reset   = 1'b1;
        a_in    = 1'b0;
        b_in    = 1'b0;
        clear   = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", {24'd0, count}, 32'd0);
        chk("rst_step", {31'd0, step}, 32'd0);
        chk("rst_dir", {31'd0, dir}, 32'd1);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("init00_count", {24'd0, count}, 32'd0);
        chk("init00_pulses", pulses, 32'd0);

        do_step(1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "pre_up1");
        do_step(1'b1, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "pre_up2");
        do_step(1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "pre_dn1");

        // Async reset mid-clock, then first accepted value 11 must not step.
        @(posedge clk);
        #3;
        reset = 1'b1;
        a_in  = 1'b1;
        b_in  = 1'b1;
        #1;
        chk("arst_count", {24'd0, count}, 32'd0);
        chk("arst_step", {31'd0, step}, 32'd0);
        chk("arst_dir", {31'd0, dir}, 32'd1);
        chk("arst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        p0    = pulses;
        repeat (12) @(posedge clk);
        #1;
        chk("init11_pulses", pulses, p0);
        chk("init11_count", {24'd0, count}, 32'd0);
        chk("init11_err", {31'd0, err}, 32'd0);
        do_step(1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "init11_up");

        // Re-initialise at 00 and run four full up cycles.
        @(negedge clk);
        reset = 1'b1;
        a_in  = 1'b0;
        b_in  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("reinit_count", {24'd0, count}, 32'd0);
        p0 = pulses;
        for (int i = 0; i < 16; i++) begin
            case (i % 4)
                0: do_step(1'b1, 1'b0, 8'(i + 1), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "up16");
                1: do_step(1'b1, 1'b1, 8'(i + 1), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "up16");
                2: do_step(1'b0, 1'b1, 8'(i + 1), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "up16");
                default: do_step(1'b0, 1'b0, 8'(i + 1), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "up16");
            endcase
        end
        chk("up16_pulses", pulses - p0, 32'd16);

        // clear on the same cycle as an up step at count 0x10.
        do_step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "clr_step");

        // Up to 2, down through zero, wrap back up.
        do_step(1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "w_up1");
        do_step(1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "w_up2");
        do_step(1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "w_dn1");
        do_step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "w_dn0");
        do_step(1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "w_dnff");
        do_step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "w_upwrap");
        do_step(1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "w_dn_to00");

        // Two-cycle glitch on A is rejected; a held change is accepted.
        p0 = pulses;
        @(negedge clk);
        a_in = 1'b1;
        repeat (2) @(negedge clk);
        a_in = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("glitch_pulses", pulses, p0);
        chk("glitch_count", {24'd0, count}, 32'h0000_00FF);
        do_step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "held_up");
        do_step(1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "held_dn");

        // Illegal jumps, err stickiness and set-over-clear priority.
        do_step(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "ill_00_11");
        do_step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "ill_after_up");
        do_step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "ill_with_eclr");
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("eclr_alone", {31'd0, err}, 32'd0);
        err_clr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
